// File: rtl/conv1d_v2_pkg.sv
// Shared definitions for the conv1d_engine_v2 CFU datapath.
// Holds the command opcodes, FSM state encoding, status-word bit positions,
// the quant parameter payload and the quant pipeline latency.
package conv1d_v2_pkg;

   localparam int unsigned CMD_W = 7;

   localparam logic [CMD_W-1:0] CMD_CAPACITY    = 7'd0;
   localparam logic [CMD_W-1:0] CMD_WR_INPUT    = 7'd1;
   localparam logic [CMD_W-1:0] CMD_WR_FILTER   = 7'd2;
   localparam logic [CMD_W-1:0] CMD_SET_OFFSET  = 7'd3;
   localparam logic [CMD_W-1:0] CMD_SET_DEPTH   = 7'd5;
   localparam logic [CMD_W-1:0] CMD_START       = 7'd6;
   localparam logic [CMD_W-1:0] CMD_RD_RESULT   = 7'd7;
   localparam logic [CMD_W-1:0] CMD_SET_START_X = 7'd8;
   localparam logic [CMD_W-1:0] CMD_STATUS      = 7'd9;
   localparam logic [CMD_W-1:0] CMD_SET_KLEN    = 7'd10;
   localparam logic [CMD_W-1:0] CMD_SET_BIAS    = 7'd12;
   localparam logic [CMD_W-1:0] CMD_SET_MULT    = 7'd13;
   localparam logic [CMD_W-1:0] CMD_SET_SHIFT   = 7'd14;
   localparam logic [CMD_W-1:0] CMD_SET_ACT_MIN = 7'd15;
   localparam logic [CMD_W-1:0] CMD_SET_ACT_MAX = 7'd16;
   localparam logic [CMD_W-1:0] CMD_SET_OUT_OFF = 7'd17;
   localparam logic [CMD_W-1:0] CMD_RD_ACC      = 7'd19;
   localparam logic [CMD_W-1:0] CMD_CLR_ERR     = 7'd20;

   localparam int unsigned STATUS_DONE_BIT = 0;
   localparam int unsigned STATUS_ERR_BIT  = 1;

   // Edges from quant sampling start to ret_valid being consumed.
   localparam int unsigned QUANT_LATENCY = 2;

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, QUANT} state_t;

   typedef struct packed {
      logic signed [31:0] bias;
      logic signed [31:0] out_mult;
      logic signed [31:0] out_shift;
      logic signed [31:0] act_min;
      logic signed [31:0] act_max;
      logic signed [31:0] out_offset;
   } quant_params_t;

   // Commands that mutate configuration or buffers; refused while busy.
   function automatic logic is_config_cmd(input logic [CMD_W-1:0] c);
      return (c == CMD_WR_INPUT) || (c == CMD_WR_FILTER) || (c == CMD_SET_OFFSET) ||
             (c == CMD_SET_DEPTH) || (c == CMD_START) || (c == CMD_SET_START_X) ||
             (c == CMD_SET_KLEN) || ((c >= CMD_SET_BIAS) && (c <= CMD_SET_OUT_OFF));
   endfunction

endpackage

// File: rtl/conv1d_mac_lanes.sv
// LANES-wide masked multiply array with a registered product stage and an
// adder tree behind it.
// Ports: issue/lane_mask/in_bytes/filt_bytes/input_offset in; sum_valid and
// chunk_sum_c (sum of the registered products) out.
module conv1d_mac_lanes #(
   parameter int unsigned LANES = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               issue,
   input  logic [LANES-1:0]   lane_mask,
   input  logic [LANES*8-1:0] in_bytes,
   input  logic [LANES*8-1:0] filt_bytes,
   input  logic signed [31:0] input_offset,
   output logic               sum_valid,
   output logic [31:0]        chunk_sum_c
);

   logic signed [31:0] prod_c [LANES];
   logic signed [31:0] prod_q [LANES];

   // Masked lanes contribute zero so the tail chunk needs no special case.
   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         prod_c[j] = '0;
         if (lane_mask[j])
            prod_c[j] = (32'(signed'(in_bytes[j*8 +: 8])) + input_offset) *
                        32'(signed'(filt_bytes[j*8 +: 8]));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_valid <= 1'b0;
         for (int j = 0; j < LANES; j++) prod_q[j] <= '0;
      end else begin
         sum_valid <= issue;
         if (issue)
            for (int j = 0; j < LANES; j++) prod_q[j] <= prod_c[j];
      end
   end

   always_comb begin
      chunk_sum_c = '0;
      for (int j = 0; j < LANES; j++) chunk_sum_c = chunk_sum_c + prod_q[j];
   end

endmodule

// File: rtl/quant.sv
// Requantisation: ((acc+bias) scaled by a Q31 multiplier and power-of-two
// shift) + output_offset, clamped to [activation_min, activation_max].
// Ports: clk/reset, start pulse, acc and parameters in; ret_valid pulse and
// ret out two edges after start is sampled.
module quant (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic signed [31:0] acc,
   input  logic signed [31:0] bias,
   input  logic signed [31:0] output_multiplier,
   input  logic signed [31:0] output_shift,
   input  logic signed [31:0] output_offset,
   input  logic signed [31:0] activation_min,
   input  logic signed [31:0] activation_max,
   output logic               ret_valid,
   output logic [31:0]        ret
);

   logic signed [31:0] x_c, xs_c, neg_c;
   logic        [4:0]  lsh_c, rsh_c, rsh_q;
   logic signed [63:0] prod_c, prod_q, rounded_c;
   logic signed [31:0] hm_c, rnd_c, shr_c, y_c, clip_c;
   logic               v1_q;

   // Stage 1: bias, left shift, full-width multiply.
   always_comb begin
      x_c   = acc + bias;
      lsh_c = 5'd0;
      rsh_c = 5'd0;
      neg_c = -output_shift;
      if (output_shift > 32'sd0)
         lsh_c = (output_shift > 32'sd31) ? 5'd31 : 5'(output_shift);
      else if (output_shift < 32'sd0)
         rsh_c = (neg_c > 32'sd31) ? 5'd31 : 5'(neg_c);
      xs_c   = x_c <<< lsh_c;
      prod_c = 64'(xs_c) * 64'(output_multiplier);
   end

   // Stage 2: rounding doubling-high-mul, rounding right shift, offset, clamp.
   always_comb begin
      rounded_c = (prod_q + 64'sd1073741824) >>> 31;
      hm_c      = 32'(rounded_c);
      rnd_c     = 32'sd0;
      shr_c     = hm_c;
      if (rsh_q != 5'd0) begin
         rnd_c = 32'sd1 <<< (rsh_q - 5'd1);
         shr_c = (hm_c + rnd_c) >>> rsh_q;
      end
      y_c    = shr_c + output_offset;
      clip_c = y_c;
      if (y_c < activation_min) clip_c = activation_min;
      if (y_c > activation_max) clip_c = activation_max;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q      <= 1'b0;
         prod_q    <= '0;
         rsh_q     <= '0;
         ret_valid <= 1'b0;
         ret       <= '0;
      end else begin
         v1_q      <= start;
         ret_valid <= v1_q;
         if (start) begin
            prod_q <= prod_c;
            rsh_q  <= rsh_c;
         end
         if (v1_q) ret <= clip_c;
      end
   end

endmodule

// File: rtl/conv1d_engine_v2.sv
// conv1d CFU datapath: int8 input ring buffer and filter buffer, LANES-wide
// pipelined MAC over a runtime kernel length, then requantisation.
// Ports: clk, reset (sync, active-high), en/cmd/inp0/inp1 command in;
// ret registered response, output_buffer_valid tied high.
module conv1d_engine_v2
   import conv1d_v2_pkg::*;
#(
   parameter int unsigned LANES              = 8,
   parameter int unsigned KERNEL_LENGTH_MAX  = 8,
   parameter int unsigned MAX_INPUT_CHANNELS = 128,
   parameter int unsigned BUF_DEPTH          = KERNEL_LENGTH_MAX * MAX_INPUT_CHANNELS,
   parameter int unsigned ADDR_W             = $clog2(BUF_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [CMD_W-1:0] cmd,
   input  logic [31:0]      inp0,
   input  logic [31:0]      inp1,
   output logic [31:0]      ret,
   output logic             output_buffer_valid
);

   // Wide enough for k+LANES and i+LANES with N up to BUF_DEPTH.
   localparam int unsigned CNT_W = ADDR_W + 2;

   logic [7:0]         in_buf   [BUF_DEPTH];
   logic [7:0]         filt_buf [BUF_DEPTH];

   state_t             state, state_next;
   logic               done, error, q_start;
   logic signed [31:0] acc, input_offset;
   logic [31:0]        input_depth, kernel_length, start_x, q_result;
   quant_params_t      qp;
   logic [CNT_W-1:0]   n_total, k_cnt, i_idx, i_step_c;

   logic               busy_c, wr_cmd_c, addr_bad_c, start_bad_c, blocked_c, start_ok_c;
   logic [63:0]        n_full_c;
   logic               mac_issue_c, drain_c, finish_c;
   logic [LANES-1:0]   lane_mask_c;
   logic [LANES*8-1:0] in_bytes_c, filt_bytes_c;
   logic               sum_valid, q_valid;
   logic [31:0]        chunk_sum_c, q_ret, status_c;

   assign output_buffer_valid = 1'b1;

   // Command decode and legality checks.
   always_comb begin
      busy_c      = (state != IDLE);
      wr_cmd_c    = en && ((cmd == CMD_WR_INPUT) || (cmd == CMD_WR_FILTER));
      addr_bad_c  = (inp0[1:0] != 2'b00) || ((33'(inp0) + 33'd3) >= 33'(BUF_DEPTH));
      n_full_c    = 64'(kernel_length) * 64'(input_depth);
      start_bad_c = (n_full_c == 64'd0) || (n_full_c > 64'(BUF_DEPTH)) ||
                    (start_x >= kernel_length);
      blocked_c   = en && busy_c && is_config_cmd(cmd);
      start_ok_c  = en && (cmd == CMD_START) && !busy_c && !start_bad_c;
      status_c    = '0;
      status_c[STATUS_DONE_BIT] = done;
      status_c[STATUS_ERR_BIT]  = error;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      mac_issue_c = 1'b0;
      drain_c     = 1'b0;
      finish_c    = 1'b0;
      case (state)
         IDLE:  if (start_ok_c) state_next = MAC;
         MAC: begin
            mac_issue_c = 1'b1;
            if ((k_cnt + CNT_W'(LANES)) >= n_total) state_next = DRAIN;
         end
         DRAIN: begin
            drain_c    = 1'b1;
            state_next = QUANT;
         end
         QUANT: if (q_valid) begin
            finish_c   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Per-lane addressing: filter runs linearly from k, input wraps modulo N.
   always_comb begin
      lane_mask_c  = '0;
      in_bytes_c   = '0;
      filt_bytes_c = '0;
      for (int j = 0; j < LANES; j++) begin
         logic [CNT_W-1:0] kj, ij;
         kj = k_cnt + CNT_W'(j);
         ij = i_idx + CNT_W'(j);
         if (ij >= n_total) ij = ij - n_total;
         lane_mask_c[j] = (kj < n_total);
         if (lane_mask_c[j]) begin
            in_bytes_c[j*8 +: 8]   = in_buf[ADDR_W'(ij)];
            filt_bytes_c[j*8 +: 8] = filt_buf[ADDR_W'(kj)];
         end
      end
      i_step_c = i_idx + CNT_W'(LANES);
      if (i_step_c >= n_total) i_step_c = i_step_c - n_total;
   end

   conv1d_mac_lanes #(.LANES(LANES)) u_mac (
      .clk          (clk),
      .reset        (reset),
      .issue        (mac_issue_c),
      .lane_mask    (lane_mask_c),
      .in_bytes     (in_bytes_c),
      .filt_bytes   (filt_bytes_c),
      .input_offset (input_offset),
      .sum_valid    (sum_valid),
      .chunk_sum_c  (chunk_sum_c)
   );

   quant u_quant (
      .clk               (clk),
      .reset             (reset),
      .start             (q_start),
      .acc               (acc),
      .bias              (qp.bias),
      .output_multiplier (qp.out_mult),
      .output_shift      (qp.out_shift),
      .output_offset     (qp.out_offset),
      .activation_min    (qp.act_min),
      .activation_max    (qp.act_max),
      .ret_valid         (q_valid),
      .ret               (q_ret)
   );

   // Buffers hold their contents across reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_cmd_c && !addr_bad_c && !busy_c)
         for (int b = 0; b < 4; b++) begin
            if (cmd == CMD_WR_INPUT)
               in_buf[inp0[ADDR_W-1:0] + ADDR_W'(b)] <= inp1[b*8 +: 8];
            else
               filt_buf[inp0[ADDR_W-1:0] + ADDR_W'(b)] <= inp1[b*8 +: 8];
         end
   end

   // Command responses, configuration and MAC/quant datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ret           <= '0;
         done          <= 1'b1;
         error         <= 1'b0;
         acc           <= '0;
         input_offset  <= '0;
         input_depth   <= '0;
         kernel_length <= 32'(KERNEL_LENGTH_MAX);
         start_x       <= '0;
         qp            <= '0;
         q_start       <= 1'b0;
         q_result      <= '0;
         n_total       <= '0;
         k_cnt         <= '0;
         i_idx         <= '0;
      end else begin
         q_start <= drain_c;
         if (en) begin
            case (cmd)
               CMD_CAPACITY:  ret <= 32'(BUF_DEPTH);
               CMD_RD_RESULT: ret <= q_result;
               CMD_STATUS:    ret <= status_c;
               CMD_RD_ACC:    ret <= acc;
               CMD_CLR_ERR:   error <= 1'b0;
               CMD_WR_INPUT, CMD_WR_FILTER, CMD_START: ;
               CMD_SET_OFFSET:  if (!busy_c) input_offset  <= inp1;
               CMD_SET_DEPTH:   if (!busy_c) input_depth   <= inp1;
               CMD_SET_START_X: if (!busy_c) start_x       <= inp1;
               CMD_SET_KLEN:    if (!busy_c) kernel_length <= inp1;
               CMD_SET_BIAS:    if (!busy_c) qp.bias       <= inp1;
               CMD_SET_MULT:    if (!busy_c) qp.out_mult   <= inp1;
               CMD_SET_SHIFT:   if (!busy_c) qp.out_shift  <= inp1;
               CMD_SET_ACT_MIN: if (!busy_c) qp.act_min    <= inp1;
               CMD_SET_ACT_MAX: if (!busy_c) qp.act_max    <= inp1;
               CMD_SET_OUT_OFF: if (!busy_c) qp.out_offset <= inp1;
               default:       ret <= '0;
            endcase
         end
         if ((wr_cmd_c && addr_bad_c) || blocked_c ||
             (en && (cmd == CMD_START) && !busy_c && start_bad_c))
            error <= 1'b1;
         if (start_ok_c) begin
            acc     <= '0;
            k_cnt   <= '0;
            i_idx   <= CNT_W'(start_x * input_depth);
            n_total <= CNT_W'(n_full_c);
            done    <= 1'b0;
         end
         if (mac_issue_c) begin
            k_cnt <= k_cnt + CNT_W'(LANES);
            i_idx <= i_step_c;
         end
         if (sum_valid) acc <= acc + chunk_sum_c;
         if (finish_c) begin
            q_result <= q_ret;
            done     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_conv1d_engine_v2.sv
// Directed bench for conv1d_engine_v2 with hand-computed expectations.
module tb_conv1d_engine_v2;
   import conv1d_v2_pkg::*;

   logic        clk = 1'b0;
   logic        reset, en, obv;
   logic [6:0]  cmd;
   logic [31:0] inp0, inp1, ret;
   int          checks = 0;
   int          failures = 0;
   int          polls;

   always #5 clk = ~clk;

   conv1d_engine_v2 dut (
      .clk                 (clk),
      .reset               (reset),
      .en                  (en),
      .cmd                 (cmd),
      .inp0                (inp0),
      .inp1                (inp1),
      .ret                 (ret),
      .output_buffer_valid (obv)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // One command per cycle: drive at negedge, response visible at next negedge.
   task automatic do_cmd(input logic [6:0] c, input logic [31:0] a, input logic [31:0] v);
      en = 1'b1; cmd = c; inp0 = a; inp1 = v;
      @(negedge clk);
      en = 1'b0; cmd = '0; inp0 = '0; inp1 = '0;
   endtask

   task automatic fill(input logic [6:0] c, input int words, input logic [31:0] v);
      for (int w = 0; w < words; w++) do_cmd(c, 32'(w * 4), v);
   endtask

   task automatic wait_done(input string tag, output int n);
      n = 0;
      do begin
         do_cmd(CMD_STATUS, 0, 0);
         n++;
      end while (ret[0] !== 1'b1 && n < 3000);
      check(tag, 32'(ret[0]), 32'd1);
   endtask

   task automatic config_job(input int depth, input int klen, input int sx);
      do_cmd(CMD_SET_DEPTH, 0, 32'(depth));
      do_cmd(CMD_SET_KLEN, 0, 32'(klen));
      do_cmd(CMD_SET_START_X, 0, 32'(sx));
   endtask

   // Start, check exact done latency, then raw acc and quantised result.
   task automatic run_job(input string tag, input int n, input int exp_acc, input int exp_q);
      int p;
      do_cmd(CMD_START, 0, 0);
      wait_done({tag, "_done"}, p);
      // first poll seeing done = latency + 1 (completion-cycle poll shows old status)
      check({tag, "_latency"}, 32'(p), 32'((n + 7) / 8 + 2 + QUANT_LATENCY + 1));
      do_cmd(CMD_RD_ACC, 0, 0);
      check({tag, "_acc"}, ret, 32'(exp_acc));
      do_cmd(CMD_RD_RESULT, 0, 0);
      check({tag, "_quant"}, ret, 32'(exp_q));
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; cmd = '0; inp0 = '0; inp1 = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset_ret", ret, 32'd0);
      check("obuf_valid", 32'(obv), 32'd1);
      do_cmd(CMD_CAPACITY, 0, 0);
      check("capacity", ret, 32'd1024);
      do_cmd(CMD_WR_INPUT, 0, 32'h0101_0101);
      check("ret_hold", ret, 32'd1024);
      do_cmd(CMD_STATUS, 0, 0);
      check("status_reset", ret, 32'd1);
      do_cmd(7'd4, 0, 0);
      check("unknown_op", ret, 32'd0);

      // quant identity
      do_cmd(CMD_SET_BIAS, 0, 0);
      do_cmd(CMD_SET_MULT, 0, 32'h4000_0000);
      do_cmd(CMD_SET_SHIFT, 0, 32'd1);
      do_cmd(CMD_SET_ACT_MIN, 0, -32'sd128);
      do_cmd(CMD_SET_ACT_MAX, 0, 32'd127);
      do_cmd(CMD_SET_OUT_OFF, 0, 0);

      // basic: 16 lanes of 1*2
      fill(CMD_WR_INPUT, 4, 32'h0101_0101);
      fill(CMD_WR_FILTER, 4, 32'h0202_0202);
      do_cmd(CMD_SET_OFFSET, 0, 0);
      config_job(2, 8, 0);
      run_job("basic", 16, 32, 32);

      // input offset 3: 16*2*4=128, clipped to 127
      do_cmd(CMD_SET_OFFSET, 0, 32'd3);
      run_job("offset", 16, 128, 127);

      // negative filter: 16*(-1)
      do_cmd(CMD_SET_OFFSET, 0, 0);
      fill(CMD_WR_FILTER, 4, 32'hFFFF_FFFF);
      run_job("negative", 16, -16, -16);

      // wrap: input[n]=n, N=24, start_x=7 -> sum 0..23 = 276
      for (int w = 0; w < 6; w++)
         do_cmd(CMD_WR_INPUT, 32'(w * 4),
                {8'(w * 4 + 3), 8'(w * 4 + 2), 8'(w * 4 + 1), 8'(w * 4)});
      fill(CMD_WR_FILTER, 6, 32'h0101_0101);
      config_job(3, 8, 7);
      run_job("wrap_sum", 24, 276, 127);

      // straddle: i=21, f[2]=5,f[3]=1,f[4]=1 -> 5*in[23]+in[0]+in[1] = 116
      fill(CMD_WR_FILTER, 6, 32'h0);
      do_cmd(CMD_WR_FILTER, 0, 32'h0105_0000);
      do_cmd(CMD_WR_FILTER, 4, 32'h0000_0001);
      run_job("straddle", 24, 116, 116);

      // tail mask: N=9 with all-ones beyond -> 9
      do_cmd(CMD_SET_START_X, 0, 0);
      fill(CMD_WR_INPUT, 4, 32'h0101_0101);
      fill(CMD_WR_FILTER, 4, 32'h0101_0101);
      config_job(3, 3, 0);
      run_job("tail", 9, 9, 9);
      do_cmd(CMD_STATUS, 0, 0);
      check("tail_status", ret, 32'd1);

      // busy protection: filter write during MAC is dropped
      fill(CMD_WR_FILTER, 4, 32'h0202_0202);
      config_job(2, 8, 0);
      do_cmd(CMD_START, 0, 0);
      do_cmd(CMD_WR_FILTER, 0, 32'h7F7F_7F7F);
      do_cmd(CMD_STATUS, 0, 0);
      check("busy_status", ret, 32'd2);
      wait_done("busy_done", polls);
      check("busy_status_done", ret, 32'd3);
      do_cmd(CMD_RD_ACC, 0, 0);
      check("busy_acc", ret, 32'd32);
      do_cmd(CMD_CLR_ERR, 0, 0);
      do_cmd(CMD_STATUS, 0, 0);
      check("clr_err", ret, 32'd1);

      // illegal starts and writes
      do_cmd(CMD_SET_KLEN, 0, 0);
      do_cmd(CMD_START, 0, 0);
      do_cmd(CMD_STATUS, 0, 0);
      check("klen0_start", ret, 32'd3);
      do_cmd(CMD_CLR_ERR, 0, 0);
      config_job(2, 8, 8);
      do_cmd(CMD_START, 0, 0);
      do_cmd(CMD_STATUS, 0, 0);
      check("startx_start", ret, 32'd3);
      do_cmd(CMD_CLR_ERR, 0, 0);
      config_job(129, 8, 0);
      do_cmd(CMD_START, 0, 0);
      do_cmd(CMD_STATUS, 0, 0);
      check("n_over_start", ret, 32'd3);
      do_cmd(CMD_CLR_ERR, 0, 0);
      do_cmd(CMD_WR_INPUT, 2, 32'h1234_5678);
      do_cmd(CMD_STATUS, 0, 0);
      check("misaligned_wr", ret, 32'd3);
      do_cmd(CMD_CLR_ERR, 0, 0);
      do_cmd(CMD_WR_INPUT, 1024, 32'h1234_5678);
      do_cmd(CMD_STATUS, 0, 0);
      check("oob_wr", ret, 32'd3);
      do_cmd(CMD_CLR_ERR, 0, 0);
      do_cmd(CMD_WR_FILTER, 1020, 32'h1234_5678);
      do_cmd(CMD_STATUS, 0, 0);
      check("last_word_wr", ret, 32'd1);

      // reset mid-MAC (N=1024)
      config_job(128, 8, 0);
      do_cmd(CMD_START, 0, 0);
      do_cmd(CMD_STATUS, 0, 0);
      check("long_busy", ret, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_ret", ret, 32'd0);
      do_cmd(CMD_STATUS, 0, 0);
      check("midreset_status", ret, 32'd1);
      do_cmd(CMD_RD_ACC, 0, 0);
      check("midreset_acc", ret, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv1d_engine_v2.md
Name: conv1d_engine_v2

Overview:
- Parametrised successor of the v12 conv1d CFU datapath: int8 input ring buffer and filter buffer, a LANES-wide multiply-accumulate, then requantisation through the existing quant module.
- Adds a runtime kernel length, tail-lane masking, a one-stage MAC pipeline and an explicit FSM.
- Adds busy protection, with an error flag for illegal commands and addresses.
- Sits behind the CFU command decoder: cmd/inp0/inp1 in, registered ret out.

Parameters:
- LANES, 8, products summed per MAC cycle (power of two, 4..32).
- KERNEL_LENGTH_MAX, 8, largest runtime kernel length.
- MAX_INPUT_CHANNELS, 128, largest input_depth.
- BUF_DEPTH, KERNEL_LENGTH_MAX*MAX_INPUT_CHANNELS, bytes per buffer (multiple of 4 and of LANES).
- ADDR_W, $clog2(BUF_DEPTH), buffer address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  command valid; one command per cycle.
- cmd  in  7  opcode.
- inp0  in  32  address / operand 0.
- inp1  in  32  value / operand 1.
- ret  out  32  registered response.
- output_buffer_valid  out  1  tied 1 (CFU response always ready).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - ret=0, state=IDLE, done=1, error=0, acc=0.
  - input_offset=0, input_depth=0, kernel_length=KERNEL_LENGTH_MAX, start_x=0.
  - Quant parameters 0.
  - Buffers not reset.
  - Reset mid-computation aborts immediately; quant start deasserted.
- Command timing: a command with en=1 at edge N produces ret at edge N+1. Commands without a ret result leave ret unchanged.
- Opcodes:
  - 0: ret=BUF_DEPTH.
  - 1: write input word. inp1 bytes [7:0]..[31:24] go to addr..addr+3.
  - 2: write filter word, same byte order.
  - 3: input_offset=inp1.
  - 5: input_depth=inp1.
  - 6: start.
  - 7: ret=quantised result.
  - 8: start_x=inp1.
  - 9: ret={30'b0,error,done}.
  - 10: kernel_length=inp1.
  - 12-17: bias, output_multiplier, output_shift, activation_min, activation_max, output_offset.
  - 19: ret=raw acc.
  - 20: clear error.
  - Other opcodes: ret=0.
- Address checks: a write with addr[1:0]!=0 or addr+3>=BUF_DEPTH is dropped and sets error.
- Busy protection: while state!=IDLE, opcodes 1,2,3,5,6,8,10,12-17 are dropped and set error. Opcodes 0,7,9,19,20 are always served.
- Start (opcode 6) in IDLE: computes N=kernel_length*input_depth.
  - If N==0, N>BUF_DEPTH or start_x>=kernel_length: set error, stay IDLE, done stays 1.
  - Otherwise: acc=0, k=0, i=start_x*input_depth, done=0, go to MAC.
- MAC state (one LANES chunk per cycle):
  - Lane j is valid iff k+j<N. Invalid lanes contribute 0.
  - Input index = (i+j) wrapped modulo N; wrap applies per lane, so a chunk may straddle the end.
  - Stage 1 registers the LANES products filter*(input+input_offset): signed 8b x signed 9b+ -> 32b.
  - Stage 2 adds their sum to acc.
  - k+=LANES; i=(i+LANES) mod N.
  - When k+LANES>=N after issuing the final chunk, go to DRAIN.
- DRAIN: one cycle to retire stage 2. Then pulse quant start for one cycle and go to QUANT.
- QUANT: wait for quant ret_valid. Then latch the result, set done=1, go to IDLE.
- Latency: start-to-done = ceil(N/LANES)+2+Q cycles, where Q is the quant latency.
- Arithmetic: acc is signed 32b, two's-complement wrap, no saturation before quant.
- Simultaneous events: a poll (opcode 9) in the same cycle as completion returns the pre-update status. Done becomes visible one poll later.

Decomposition:
- Package conv1d_v2_pkg:
  - opcode localparams (CMD_CAPACITY, CMD_WR_INPUT, ... CMD_CLR_ERR);
  - state enum {IDLE, MAC, DRAIN, QUANT};
  - status bit positions.
- Sub-module conv1d_mac_lanes (LANES): the masked product array plus adder tree with its stage-1 register. Outputs the registered chunk sum.
- quant is instantiated unchanged.

Test Plan:
- Reset, then opcode 0 and opcode 9: ret=1024, then ret=1 (done=1, error=0).
- depth=2, klen=8, start_x=0, all input=1, filter=2, offset=0, quant identity (multiplier=1<<30, shift=1, min=-128, max=127): start, poll until done -> raw acc (19)=32 and opcode 7 ret=32 clipped/quantised per quant; done occurs exactly ceil(16/8)+2+Q cycles after start.
- Wrap: depth=3, klen=8 (N=24), start_x=7, input[n]=n mod 24, filter all 1 -> acc=276 (same as start_x=0), and chunk straddling index 23->0 verified.
- Tail mask: depth=3, klen=3 (N=9), LANES=8, filter all 1, input all 1 -> acc=9, not 16.
- Busy protection: start, then opcode 2 at addr 0 during MAC -> filter unchanged, status ret=2'b10 after done then 2'b11; opcode 20 clears error.
- Illegal start and writes: klen=0 start -> error=1, done stays 1; opcode 1 with addr=2 -> dropped, error=1; reset asserted mid-MAC -> status ret=1 next poll, acc=0.
